// File: rtl/crossbar_8x8_read_arb_if.sv
// Bus bundle for the 8x8 LSU-to-bank-group read crossbar.
// master: the LSU/bank side that drives requests and bank data.
// slave : the crossbar itself.
interface crossbar_8x8_read_arb_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [8*(4+ADDR_W)-1:0] LSU_R_req;
    logic [7:0]              LSU_R_gnt;
    logic [8*(1+ADDR_W)-1:0] R_BG;
    logic [8*DATA_W-1:0]     BG_R_data;
    logic [7:0]              LSU_R_valid;
    logic [8*DATA_W-1:0]     LSU_R_data;
    logic [31:0]             conflict_cnt;

    modport master (
        output LSU_R_req,
        output BG_R_data,
        input  LSU_R_gnt,
        input  R_BG,
        input  LSU_R_valid,
        input  LSU_R_data,
        input  conflict_cnt
    );

    modport slave (
        input  LSU_R_req,
        input  BG_R_data,
        output LSU_R_gnt,
        output R_BG,
        output LSU_R_valid,
        output LSU_R_data,
        output conflict_cnt
    );
endinterface

// File: rtl/crossbar_8x8_read_arb.sv
// 8x8 read crossbar: per-bank round-robin arbitration of LSU read requests,
// per-bank tag pipeline of depth RD_LAT, and registered return steering.
// Optional conflict performance counter: define CROSSBAR_RD_PERF_CNT_EN.
module crossbar_8x8_read_arb #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic rst,
    crossbar_8x8_read_arb_if.slave bus
);
    localparam int REQ_W = 4 + ADDR_W;
    localparam int BG_W  = 1 + ADDR_W;

    logic [2:0]        req_sel  [8];
    logic [7:0]        req_ren;
    logic [ADDR_W-1:0] req_addr [8];

    logic [2:0]        rr_q  [8];
    logic [2:0]        rr_d  [8];
    logic [3:0]        tag_q [8][RD_LAT];
    logic [3:0]        tag_d [8][RD_LAT];
    logic [3:0]        tag_in [8];
    logic [7:0]        valid_q;
    logic [7:0]        valid_d;
    logic [DATA_W-1:0] data_q [8];
    logic [DATA_W-1:0] data_d [8];
    logic [7:0]        gnt;
    logic [BG_W-1:0]   r_bg [8];

    // Split the packed request bus into per-LSU fields.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            req_addr[k] = bus.LSU_R_req[k*REQ_W +: ADDR_W];
            req_ren[k]  = bus.LSU_R_req[k*REQ_W + ADDR_W];
            req_sel[k]  = bus.LSU_R_req[k*REQ_W + ADDR_W + 1 +: 3];
        end
    end

    // Per-bank round-robin search from rr_ptr; grants are suppressed in reset.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        logic [2:0] win;
        gnt = '0;
        for (int b = 0; b < 8; b++) begin
            found = 1'b0;
            idx   = '0;
            win   = '0;
            for (int j = 0; j < 8; j++) begin
                idx = rr_q[b] + 3'(j);
                if (!found && req_ren[idx] && (req_sel[idx] == 3'(b))) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            if (rst) begin
                found = 1'b0;
            end
            rr_d[b]   = found ? (win + 3'd1) : rr_q[b];
            tag_in[b] = {found, win};
            r_bg[b]   = found ? {1'b1, req_addr[win]} : '0;
            if (found) begin
                gnt[win] = 1'b1;
            end
        end
    end

    // Tag shift register: new tag enters stage 0, the oldest emerges at RD_LAT-1.
    always_comb begin
        for (int b = 0; b < 8; b++) begin
            tag_d[b][0] = tag_in[b];
            for (int s = 1; s < RD_LAT; s++) begin
                tag_d[b][s] = tag_q[b][s-1];
            end
        end
    end

    // Steer emerging bank data to the tagged LSU; untouched slices hold.
    always_comb begin
        valid_d = '0;
        data_d  = data_q;
        for (int b = 0; b < 8; b++) begin
            if (tag_q[b][RD_LAT-1][3]) begin
                valid_d[tag_q[b][RD_LAT-1][2:0]] = 1'b1;
                data_d[tag_q[b][RD_LAT-1][2:0]]  = bus.BG_R_data[b*DATA_W +: DATA_W];
            end
        end
    end

    // Arbitration pointers, tag pipeline and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int b = 0; b < 8; b++) begin
                rr_q[b]   <= '0;
                data_q[b] <= '0;
                for (int s = 0; s < RD_LAT; s++) begin
                    tag_q[b][s] <= '0;
                end
            end
        end else begin
            valid_q <= valid_d;
            for (int b = 0; b < 8; b++) begin
                rr_q[b]   <= rr_d[b];
                data_q[b] <= data_d[b];
                for (int s = 0; s < RD_LAT; s++) begin
                    tag_q[b][s] <= tag_d[b][s];
                end
            end
        end
    end

    assign bus.LSU_R_gnt   = gnt;
    assign bus.LSU_R_valid = valid_q;

    for (genvar g = 0; g < 8; g++) begin : g_pack
        assign bus.R_BG[g*BG_W +: BG_W]         = r_bg[g];
        assign bus.LSU_R_data[g*DATA_W +: DATA_W] = data_q[g];
    end

`ifdef CROSSBAR_RD_PERF_CNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [3:0]  conf;

    // Every requesting LSU is eligible on exactly one bank, so losers = requests - grants.
    always_comb begin
        logic [32:0] sum;
        conf  = 4'($countones(req_ren)) - 4'($countones(gnt));
        sum   = {1'b0, cnt_q} + 33'(conf);
        cnt_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    end

    // Saturating conflict counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.conflict_cnt = cnt_q;
`else
    assign bus.conflict_cnt = 32'h0;
`endif
endmodule

// File: doc/crossbar_8x8_read_arb.md
Name: crossbar_8x8_read_arb

Overview:
- Read-side counterpart of the 8x8 LSU-to-bank-group write crossbar.
- Routes read requests from 8 LSUs to 8 bank groups (BG), with round-robin arbitration per bank on conflicts.
- Tracks each grant through the bank read latency and steers returning bank data back to the requesting LSU as a registered, valid-qualified response.

Parameters:
- ADDR_W, 10, bank-local read address width.
- DATA_W, 32, read data width.
- RD_LAT, 1, bank read latency in cycles from R_BG request to BG_R_data valid. Legal values: 1..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- LSU_R_req  input  8*(4+ADDR_W)  slice k = {sel[2:0], Ren, addr[ADDR_W-1:0]} for LSU k; sel is the target BG.
- LSU_R_gnt  output  8  combinational; bit k=1 means LSU k's request is accepted this cycle.
- R_BG  output  8*(1+ADDR_W)  slice b = {Ren, addr} to bank group b; all zero when bank b has no grant.
- BG_R_data  input  8*DATA_W  slice b = read data from bank group b, valid RD_LAT cycles after its request.
- LSU_R_valid  output  8  registered; bit k=1 means LSU_R_data slice k holds a response.
- LSU_R_data  output  8*DATA_W  registered; slice k = response data for LSU k.
- conflict_cnt  output  32  performance counter; see Optional Feature.

Behaviour:
- Reset: rst is asynchronous and active-high. Asserting it clears:
  - all round-robin pointers rr_ptr[b] to 0;
  - all in-flight tags;
  - LSU_R_valid to 0 and LSU_R_data to 0;
  - conflict_cnt to 0.
- Reset mid-operation: in-flight reads are dropped, with no response ever issued. During reset, LSU_R_gnt and R_BG are 0.
- Request eligibility: LSU k requests bank b iff Ren_k=1 and sel_k==b. Slices with Ren=0 are ignored entirely.
- Arbitration, per bank b, each cycle (combinational):
  - Search LSU indices starting at rr_ptr[b] and ascending with wrap 7->0. The first eligible LSU wins.
  - The winner gets LSU_R_gnt=1, and R_BG[b] = {1, winner addr}.
  - Losers get LSU_R_gnt=0 and must hold their request unchanged. The block keeps no queue.
- Pointer update: when bank b grants LSU w, rr_ptr[b] <= (w+1) mod 8 at the next edge. With no grant, rr_ptr[b] is unchanged.
- Grants are always one-hot per bank. Each LSU targets exactly one bank, so it receives at most one grant.
- Tag pipeline:
  - Each granted bank pushes {valid=1, lsu_id[2:0]} into a per-bank shift register of depth RD_LAT. Ungranted banks push valid=0.
  - A new grant is allowed every cycle on every bank, giving full throughput with no bubbles.
- Return path:
  - When the bank-b tag emerges valid, in the same cycle BG_R_data[b] is routed to slice lsu_id. It is registered into LSU_R_data[lsu_id], with LSU_R_valid[lsu_id]=1 at the next edge.
  - Total latency: grant in cycle T gives LSU_R_valid in cycle T+RD_LAT+1.
- With no returning data, LSU_R_valid[k]=0 and LSU_R_data[k] holds its last value.
- Simultaneous returns to the same LSU are impossible: one grant per LSU per cycle and a fixed latency.
- Simultaneous request and return on the same bank are independent and both proceed.

Optional Feature:
- Macro: CROSSBAR_RD_PERF_CNT_EN.
- Defined:
  - conflict_cnt increments each cycle by the number of eligible-but-ungranted requests in that cycle (0..7).
  - The counter saturates at 32'hFFFF_FFFF and is cleared by rst.
- Undefined:
  - conflict_cnt is tied to 32'h0 and no counter logic is built.

Test Plan:
- No conflict, RD_LAT=1:
  - Stimulus: LSU k issues sel=k, Ren=1, addr=k*4 for all k; bank returns 32'hA000_0000+b.
  - Required: all LSU_R_gnt=8'hFF in cycle T; R_BG[k]={1,k*4}; at T+2, LSU_R_valid=8'hFF and LSU_R_data[k]=32'hA000_000k.
- Two-way conflict with round-robin:
  - Stimulus: LSU 2 and LSU 5 both target sel=3 and are held for 3 cycles from reset.
  - Required: grants go LSU2, LSU5, LSU2. rr_ptr[3] goes 3, 6, 3. Each LSU receives its data 2 cycles after its own grant.
- Full contention with perf counter:
  - Stimulus: all 8 LSUs target sel=0 continuously for 8 cycles, with CROSSBAR_RD_PERF_CNT_EN defined.
  - Required: grants go LSU0..LSU7 in order, one per cycle; conflict_cnt increments by 7, 6, 5, 4, 3, 2, 1, 0, totalling 28 after 8 cycles.
- Latency parameter:
  - Stimulus: RD_LAT=3; LSU6 reads bank 1 at cycle T.
  - Required: LSU_R_valid[6] is 0 through T+3, then 1 for one cycle at T+4 carrying BG_R_data[1] as sampled at T+3.
- Reset mid-flight:
  - Stimulus: RD_LAT=2; grant LSU4 to bank 7 at T; pulse rst asynchronously at T+1.
  - Required: LSU_R_valid, LSU_R_data and conflict_cnt go to 0 immediately; no response for LSU4 at T+3; rr_ptr[7] returns to 0, so LSU0 wins the next contention.
- Ren=0 masking:
  - Stimulus: LSU1 has sel=2, Ren=0 while LSU3 has sel=2, Ren=1.
  - Required: only LSU_R_gnt[3]=1; R_BG[2]={1, LSU3 addr}; conflict_cnt does not increment.
